// File: rtl/control_fsm_pkg.sv
// rv32_ctrl_pkg: state enum, opcodes, ALU codes and mux-select encodings shared by the moka_rv32 controller and datapath
package rv32_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    return op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  endfunction
endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: controller<->datapath bundle; master = controller (in: en/op/funct3/funct7b5/zero, out: strobes, mux selects, ALU control, illegal), slave = datapath
interface control_fsm_if;
  logic       en;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic       alu_en;
  logic [2:0] alu_control;
  logic       illegal;
  modport master (
    input  en, op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_en, alu_control, illegal
  );
  modport slave (
    output en, op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_en, alu_control, illegal
  );
endinterface

// File: rtl/control_fsm_alu_decoder.sv
// alu_decoder: maps alu_op/funct3/op5/funct7b5 to alu_control and flags unsupported funct3 as illegal_funct (combinational)
module alu_decoder
  import rv32_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       illegal_funct
);
  always_comb begin
    illegal_funct = 1'b0;
    alu_control   = ALU_ADD;
    if (alu_op == ALUOP_SUB) alu_control = ALU_SUB;
    else if (alu_op == ALUOP_FUNCT)
      case (funct3)
        3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_control = ALU_SLT;
        3'b110:  alu_control = ALU_OR;
        3'b111:  alu_control = ALU_AND;
        default: illegal_funct = 1'b1;
      endcase
  end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle moka_rv32 controller; clk, async active-low rstn, bus (master modport) carrying en/op/funct3/funct7b5/zero in and strobes, mux selects, ALU control and illegal out
module control_fsm
  import rv32_ctrl_pkg::*;
(
  input logic           clk,
  input logic           rstn,
  control_fsm_if.master bus
);
  state_t     state_q, state_d;
  logic       pc_update, branch, ir_w, mem_w, reg_w, adr_src, illegal_funct, go;
  logic [1:0] result_src, src_a, src_b, alu_op;
  logic [2:0] alu_control;
  assign alu_op = (state_q == S_EXECUTER || state_q == S_EXECUTEI) ? ALUOP_FUNCT :
                  (state_q == S_BEQ) ? ALUOP_SUB : ALUOP_ADD;
  alu_decoder u_dec (
    .alu_op       (alu_op),
    .funct3       (bus.funct3),
    .op5          (bus.op[5]),
    .funct7b5     (bus.funct7b5),
    .alu_control  (alu_control),
    .illegal_funct(illegal_funct)
  );
  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    adr_src    = ADR_PC;
    result_src = RES_ALUOUT;
    src_a      = A_PC;
    src_b      = B_RS2;
    case (state_q)
      S_FETCH: begin
        ir_w       = 1'b1;
        pc_update  = 1'b1;
        src_b      = B_FOUR;
        result_src = RES_ALU;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        src_a   = A_OLDPC;
        src_b   = B_IMM;
        state_d = (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR :
                  (bus.op == OP_R)   ? S_EXECUTER :
                  (bus.op == OP_I)   ? S_EXECUTEI :
                  (bus.op == OP_BEQ) ? S_BEQ :
                  (bus.op == OP_JAL) ? S_JAL : S_TRAP;
      end
      S_MEMADR: begin
        src_a   = A_RS1;
        src_b   = B_IMM;
        state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = ADR_RESULT;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = ADR_RESULT;
        mem_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECUTER: begin
        src_a   = A_RS1;
        state_d = illegal_funct ? S_TRAP : S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a   = A_RS1;
        src_b   = B_IMM;
        state_d = illegal_funct ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        src_a   = A_RS1;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        src_a     = A_OLDPC;
        src_b     = B_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_TRAP;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= S_FETCH;
    else if (bus.en) state_q <= state_d;
  // rstn gates the strobes combinationally so FETCH's ir_write/pc_write stay quiet while held in reset
  assign go               = rstn & bus.en;
  assign bus.pc_write     = go & (pc_update | (branch & bus.zero));
  assign bus.ir_write     = go & ir_w;
  assign bus.mem_write    = go & mem_w;
  assign bus.reg_write    = go & reg_w;
  assign bus.adr_src      = adr_src;
  assign bus.result_src   = result_src;
  assign bus.alu_src_a    = src_a;
  assign bus.alu_src_b    = src_b;
  assign bus.imm_src      = imm_src_of(bus.op);
  assign bus.alu_en       = rstn & (state_q != S_TRAP);
  assign bus.alu_control  = rstn ? alu_control : ALU_ADD;
  assign bus.illegal      = rstn & ((state_q == S_TRAP) | illegal_funct);
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed per-cycle vectors pushed to a scoreboard queue, checked by a negedge monitor
module tb_control_fsm;
  logic clk = 1'b0;
  logic rstn;
  control_fsm_if bus ();
  control_fsm dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  // vector layout: pcw adr memw irw regw res[2] a[2] b[2] imm[2] alu_en ctl[3] illegal
  localparam logic [17:0] RST0 = 18'b0_0_0_0_0_10_00_10_00_0_000_0;
  localparam logic [17:0] F00  = 18'b1_0_0_1_0_10_00_10_00_1_000_0;
  localparam logic [17:0] F01  = 18'b1_0_0_1_0_10_00_10_01_1_000_0;
  localparam logic [17:0] F10  = 18'b1_0_0_1_0_10_00_10_10_1_000_0;
  localparam logic [17:0] F11  = 18'b1_0_0_1_0_10_00_10_11_1_000_0;
  localparam logic [17:0] D00  = 18'b0_0_0_0_0_00_01_01_00_1_000_0;
  localparam logic [17:0] D01  = 18'b0_0_0_0_0_00_01_01_01_1_000_0;
  localparam logic [17:0] D10  = 18'b0_0_0_0_0_00_01_01_10_1_000_0;
  localparam logic [17:0] D11  = 18'b0_0_0_0_0_00_01_01_11_1_000_0;
  localparam logic [17:0] MA00 = 18'b0_0_0_0_0_00_10_01_00_1_000_0;
  localparam logic [17:0] MA01 = 18'b0_0_0_0_0_00_10_01_01_1_000_0;
  localparam logic [17:0] MR00 = 18'b0_1_0_0_0_00_00_00_00_1_000_0;
  localparam logic [17:0] MW00 = 18'b0_0_0_0_1_01_00_00_00_1_000_0;
  localparam logic [17:0] WB00 = 18'b0_0_0_0_1_00_00_00_00_1_000_0;
  localparam logic [17:0] WB11 = 18'b0_0_0_0_1_00_00_00_11_1_000_0;
  localparam logic [17:0] TRP  = 18'b0_0_0_0_0_00_00_00_00_0_000_1;
  logic [17:0] got;
  assign got = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
                bus.alu_en, bus.alu_control, bus.illegal};
  string       names[$];
  logic [17:0] exps[$];
  string       m_name;
  logic [17:0] m_exp;
  int errors = 0;
  int checks = 0;
  always @(negedge clk)
    if (exps.size() != 0) begin
      m_name = names.pop_front();
      m_exp  = exps.pop_front();
      checks++;
      if (got !== m_exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", m_name, got, m_exp);
      end
    end
  task automatic push(input string n, input logic [17:0] v);
    names.push_back(n);
    exps.push_back(v);
  endtask
  task automatic cyc(input string n, input logic [17:0] v);
    push(n, v);
    @(posedge clk); #1;
  endtask
  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.op = op;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rstn = 1'b0;
    bus.en = 1'b1;
    bus.zero = 1'b0;
    set_instr(7'b0000011, 3'b000, 1'b0);
    @(posedge clk); #1;
    cyc("rst.init", RST0);
    rstn = 1'b1;
    cyc("lw.fetch", F00);
    cyc("lw.decode", D00);
    cyc("lw.memadr", MA00);
    cyc("lw.memread", MR00);
    cyc("lw.memwb", MW00);
    cyc("lw2.fetch", F00);
    cyc("lw2.decode", D00);
    cyc("lw2.memadr", MA00);
    push("lw2.memread", MR00);
    @(negedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    cyc("rst.low", RST0);
    cyc("rst.low2", RST0);
    rstn = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub.fetch", F00);
    cyc("sub.decode", D00);
    cyc("sub.exec", 18'b0_0_0_0_0_00_10_00_00_1_001_0);
    cyc("sub.aluwb", WB00);
    set_instr(7'b0010011, 3'b000, 1'b1);
    cyc("addi.fetch", F00);
    cyc("addi.decode", D00);
    cyc("addi.exec", 18'b0_0_0_0_0_00_10_01_00_1_000_0);
    cyc("addi.aluwb", WB00);
    set_instr(7'b0110011, 3'b010, 1'b0);
    cyc("slt.fetch", F00);
    cyc("slt.decode", D00);
    cyc("slt.exec", 18'b0_0_0_0_0_00_10_00_00_1_101_0);
    cyc("slt.aluwb", WB00);
    set_instr(7'b0010011, 3'b110, 1'b0);
    cyc("ori.fetch", F00);
    cyc("ori.decode", D00);
    cyc("ori.exec", 18'b0_0_0_0_0_00_10_01_00_1_011_0);
    cyc("ori.aluwb", WB00);
    set_instr(7'b0110011, 3'b111, 1'b0);
    cyc("and.fetch", F00);
    cyc("and.decode", D00);
    cyc("and.exec", 18'b0_0_0_0_0_00_10_00_00_1_010_0);
    cyc("and.aluwb", WB00);
    set_instr(7'b1100011, 3'b000, 1'b0);
    bus.zero = 1'b1;
    cyc("beqt.fetch", F10);
    cyc("beqt.decode", D10);
    cyc("beqt.beq", 18'b1_0_0_0_0_00_10_00_10_1_001_0);
    bus.zero = 1'b0;
    cyc("beqn.fetch", F10);
    cyc("beqn.decode", D10);
    cyc("beqn.beq", 18'b0_0_0_0_0_00_10_00_10_1_001_0);
    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal.fetch", F11);
    cyc("jal.decode", D11);
    cyc("jal.jal", 18'b1_0_0_0_0_00_01_10_11_1_000_0);
    push("jal.aluwb", WB11);
    @(negedge clk); #1;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    cyc("rstpulse.decode", D11);
    cyc("jal2.jal", 18'b1_0_0_0_0_00_01_10_11_1_000_0);
    cyc("jal2.aluwb", WB11);
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw.fetch", F01);
    cyc("sw.decode", D01);
    cyc("sw.memadr", MA01);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) cyc("sw.stall", 18'b0_1_0_0_0_00_00_00_01_1_000_0);
    bus.en = 1'b1;
    cyc("sw.memwrite", 18'b0_1_1_0_0_00_00_00_01_1_000_0);
    set_instr(7'b0110011, 3'b001, 1'b0);
    cyc("badf.fetch", F00);
    cyc("badf.decode", D00);
    cyc("badf.exec", 18'b0_0_0_0_0_00_10_00_00_1_000_1);
    cyc("badf.trap", TRP);
    cyc("badf.trap2", TRP);
    rstn = 1'b0;
    cyc("rst.trap", RST0);
    rstn = 1'b1;
    set_instr(7'b1111111, 3'b000, 1'b0);
    cyc("ill.fetch", F00);
    cyc("ill.decode", D00);
    for (int i = 0; i < 10; i++) cyc("ill.trap", TRP);
    rstn = 1'b0;
    cyc("rst.final", RST0);
    rstn = 1'b1;
    set_instr(7'b0000011, 3'b000, 1'b0);
    cyc("final.fetch", F00);
    for (int i = 0; i < 20 && exps.size() != 0; i++) @(negedge clk);
    #1;
    if (exps.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exps.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle controller for the moka_rv32 core. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the datapath muxes and write strobes, and issues `control`/`en` to the ALU. It sits between the instruction register and the shared single-ALU datapath, and it is the only source of ALU operations.

## Interface
Parameters:
- none. Opcode and ALU encodings are fixed constants from the package.

Ports:
- `clk` in 1: core clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `en` in 1: stall when low. State is held and all write strobes are forced to 0.
- `op` in 7: instruction bits [6:0].
- `funct3` in 3: instruction bits [14:12].
- `funct7b5` in 1: instruction bit 30.
- `zero` in 1: the ALU zero flag.
- `pc_write` out 1: PC register write enable.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALU result register.
- `mem_write` out 1: data memory write strobe.
- `ir_write` out 1: instruction register and old-PC write enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result mux select. 00 = ALU result register, 01 = memory data, 10 = live ALU output.
- `alu_src_a` out 2: ALU operand A select. 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b` out 2: ALU operand B select. 00 = rs2, 01 = immediate, 10 = constant 4.
- `imm_src` out 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_en` out 1: ALU enable.
- `alu_control` out 3: ALU operation code.
- `illegal` out 1: sticky unsupported-instruction flag.

## Operation
- ALU codes: ADD 000, SUB 001, AND 010, OR 011, SLT 101.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Outputs are Moore outputs, decoded from the state. The only exception is `pc_write`, which is `pc_update | (branch & zero)`.
- Every strobe not listed for a state is 0.
- `alu_op` is internal: 00 = add, 01 = sub, 10 = funct-decoded.
- Funct decode (when `alu_op` = 10), by `funct3`:
  - 000: SUB if `op[5] & funct7b5`, otherwise ADD.
  - 010: SLT.
  - 110: OR.
  - 111: AND.
  - Any other value raises `illegal`.
- `alu_en` = 1 in every state except TRAP and reset.
- `imm_src` is decoded from `op` in every state. Unsupported opcodes give 00.

States and outputs:
- FETCH:
  - `adr_src` 0, `ir_write` 1, A = PC, B = 4, add, `result_src` 10, `pc_update` 1.
  - Next: DECODE.
- DECODE:
  - A = old PC, B = imm, add (computes the branch target).
  - Next: MEMADR for lw/sw, EXECUTER for R-type, EXECUTEI for I-ALU, BEQ for beq, JAL for jal, TRAP otherwise.
- MEMADR:
  - A = rs1, B = imm, add.
  - Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `adr_src` 1, `result_src` 00. Next: MEMWB.
- MEMWB: `result_src` 01, `reg_write` 1. Next: FETCH.
- MEMWRITE: `adr_src` 1, `result_src` 00, `mem_write` 1. Next: FETCH.
- EXECUTER: A = rs1, B = rs2, funct-decoded. Next: ALUWB.
- EXECUTEI: A = rs1, B = imm, funct-decoded. Next: ALUWB.
- ALUWB: `result_src` 00, `reg_write` 1. Next: FETCH.
- BEQ:
  - A = rs1, B = rs2, sub, `result_src` 00, `branch` 1.
  - Next: FETCH.
- JAL:
  - A = old PC, B = 4, add, `result_src` 00, `pc_update` 1.
  - Next: ALUWB.
- TRAP:
  - `illegal` = 1, all strobes 0.
  - The state is only left by reset.
  - An illegal funct in EXECUTER/EXECUTEI also enters TRAP at the next edge, and no writeback occurs.

## Timing
- Reset (`rstn` low, at any time, including mid-instruction):
  - State goes to FETCH asynchronously.
  - All write strobes, `illegal` and `alu_en` read 0 while `rstn` is low.
  - `alu_control` = 000.
- On the first rising edge after reset release the FETCH outputs are active, so the fetch commits on that edge.
- Latency in cycles: lw 5, sw 4, R 4, I 4, beq 3, jal 4.
- beq taken vs. not taken is decided by `zero` in the BEQ cycle. `pc_write` is combinational in that cycle.
- `en` low:
  - The state register holds.
  - `pc_write`, `ir_write`, `mem_write` and `reg_write` are forced to 0 for that cycle.
  - Mux selects keep their state values.
  - When `en` returns high, the same state is re-executed in full.
- `en` low together with reset: reset dominates.

## Structure
- Package `rv32_ctrl_pkg` holds:
  - the state enum;
  - the opcode constants;
  - the ALU code constants (shared with the ALU);
  - the mux-select encodings.
- Sub-module `alu_decoder` (combinational): inputs `alu_op`, `funct3`, `op[5]`, `funct7b5`; outputs `alu_control` and the illegal-funct flag.

## Test plan
- Reset: assert `rstn` = 0 mid-MEMREAD, then release. Required: state FETCH, all strobes 0 during reset, `ir_write` = 1 and `pc_write` = 1 in the first cycle after release.
- lw (`op` = 0000011): required 5 cycles, FETCH → DECODE → MEMADR → MEMREAD → MEMWB. `adr_src` = 1 in MEMREAD; `reg_write` = 1 with `result_src` = 01 only in MEMWB.
- R-type sub (`op` = 0110011, `funct3` = 000, `funct7b5` = 1): required `alu_control` = 001 in EXECUTER. The same instruction with `op` = 0010011 gives 000. `funct3` = 010 gives 101.
- beq with `zero` = 1: `pc_write` = 1 in BEQ. With `zero` = 0: `pc_write` = 0. Both return to FETCH after 3 cycles with `reg_write` never asserted.
- Illegal `op` = 1111111: DECODE → TRAP, `illegal` = 1 and held for 10 cycles, no strobes. Recovery only by reset.
- Stall: hold `en` low for 3 cycles during MEMWRITE. Required: state held, `mem_write` = 0 while `en` is low, `mem_write` = 1 in the first cycle after `en` returns high, then FETCH.
